// File: rtl/c4_drop_engine.sv
// c4_drop_engine
//   Writer side of the Connect-Four board. Takes a one-hot column drop from
//   the turn logic, finds the lowest free cell, writes the piece, then checks
//   the four line directions through that cell and the full-board condition.
//
// Ports
//   clk        : system clock (also the VGA renderer clock)
//   reset      : synchronous active-high; clears board and all state
//   drop_req   : single-cycle request pulse
//   column     : one-hot column, bit 6 = leftmost column (c=0), bit 0 = c=6
//   player     : 0 = player 1 (red), 1 = player 2 (blue); sampled with drop_req
//   game_data  : owner bit per cell, index r*7+c, r=0 is the bottom row
//   empty      : 1 = cell taken, same indexing
//   busy       : high from the cycle after accept through the done cycle
//   done       : one-cycle pulse ending every accepted request
//   error      : valid with done; column full or column not one-hot
//   win_con    : 00 none, 01 player 1, 10 player 2 (sticky)
//   draw       : board full with no winner (sticky)
//   game_over  : win_con != 00 or draw
//   dbg_state  : current FSM state, for checkers and bring-up
//
// Handshake: a request is accepted only when drop_req=1 in a cycle where the
// engine is idle (busy=0) and game_over=0. Requests at any other time are
// dropped silently and never produce done. Every accepted request produces
// exactly one done pulse unless reset intervenes first.
module c4_drop_engine #(
  parameter int COLS = 7,
  parameter int ROWS = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        drop_req,
  input  logic [6:0]  column,
  input  logic        player,
  output logic [41:0] game_data,
  output logic [41:0] empty,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [1:0]  win_con,
  output logic        draw,
  output logic        game_over,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_SCAN  = 3'd2,
    S_WRITE = 3'd3,
    S_WIN   = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [6:0]  col_mask_q, col_mask_d;
  logic        player_q, player_d;
  logic [2:0]  col_q, col_d;
  logic [2:0]  row_q, row_d;
  logic [1:0]  dir_q, dir_d;
  logic        win_q, win_d;
  logic        err_q, err_d;
  logic [41:0] empty_q, empty_d;
  logic [41:0] data_q, data_d;
  logic [1:0]  win_con_q, win_con_d;
  logic        draw_q, draw_d;

  logic [5:0]  cell_idx;
  logic [2:0]  col_dec;
  logic        col_onehot;
  int          dir_dr, dir_dc;
  logic [1:0]  cnt_pos, cnt_neg;
  logic        win_hit;

  // Count contiguous cells owned by pl walking from (r0,c0) in (dr,dc),
  // excluding the start cell. Row and column bounds are checked separately so
  // a step off the right edge never lands on the next row's first cell.
  function automatic logic [1:0] side_count(
    input logic [41:0] occ,
    input logic [41:0] own,
    input logic        pl,
    input int          r0,
    input int          c0,
    input int          dr,
    input int          dc
  );
    logic [1:0] n;
    logic       run;
    int         rr;
    int         cc;
    logic [5:0] idx;
    n   = 2'd0;
    run = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      rr  = r0 + k * dr;
      cc  = c0 + k * dc;
      idx = 6'd0;
      if (run && rr >= 0 && rr < ROWS && cc >= 0 && cc < COLS) begin
        idx = 6'(rr * COLS + cc);
        if (occ[idx] && (own[idx] == pl)) n = n + 2'd1;
        else run = 1'b0;
      end else begin
        run = 1'b0;
      end
    end
    return n;
  endfunction

  assign cell_idx = ({3'b000, row_q} * 6'(COLS)) + {3'b000, col_q};

  // Exactly one bit set: nonzero and clearing the lowest set bit leaves zero.
  assign col_onehot = (col_mask_q != 7'd0) &&
                      ((col_mask_q & (col_mask_q - 7'd1)) == 7'd0);

  // Bit 6 is the leftmost column, so bit i maps to c = 6 - i.
  always_comb begin
    col_dec = 3'd0;
    for (int i = 0; i < 7; i++) begin
      if (col_mask_q[i]) col_dec = 3'(6 - i);
    end
  end

  // Direction under test this WIN cycle; both sides of the line are counted.
  always_comb begin
    dir_dr = 0;
    dir_dc = 1;
    case (dir_q)
      2'd0:    begin dir_dr = 0; dir_dc = 1;  end  // horizontal
      2'd1:    begin dir_dr = 1; dir_dc = 0;  end  // vertical
      2'd2:    begin dir_dr = 1; dir_dc = 1;  end  // diagonal up-right
      default: begin dir_dr = 1; dir_dc = -1; end  // diagonal up-left
    endcase
    cnt_pos = side_count(empty_q, data_q, player_q, int'(row_q), int'(col_q),
                         dir_dr, dir_dc);
    cnt_neg = side_count(empty_q, data_q, player_q, int'(row_q), int'(col_q),
                         -dir_dr, -dir_dc);
    win_hit = (({1'b0, cnt_pos} + {1'b0, cnt_neg}) >= 3'd3);
  end

  always_comb begin
    state_d    = state_q;
    col_mask_d = col_mask_q;
    player_d   = player_q;
    col_d      = col_q;
    row_d      = row_q;
    dir_d      = dir_q;
    win_d      = win_q;
    err_d      = err_q;
    empty_d    = empty_q;
    data_d     = data_q;
    win_con_d  = win_con_q;
    draw_d     = draw_q;

    case (state_q)
      S_IDLE: begin
        if (drop_req && !game_over) begin
          col_mask_d = column;
          player_d   = player;
          win_d      = 1'b0;
          err_d      = 1'b0;
          state_d    = S_CHECK;
        end
      end
      S_CHECK: begin
        if (col_onehot) begin
          col_d   = col_dec;
          row_d   = 3'd0;
          state_d = S_SCAN;
        end else begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      S_SCAN: begin
        if (!empty_q[cell_idx]) begin
          state_d = S_WRITE;
        end else if (row_q == 3'(ROWS - 1)) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          row_d = row_q + 3'd1;
        end
      end
      S_WRITE: begin
        empty_d[cell_idx] = 1'b1;
        data_d[cell_idx]  = player_q;
        dir_d             = 2'd0;
        state_d           = S_WIN;
      end
      S_WIN: begin
        if (win_hit) win_d = 1'b1;
        if (dir_q == 2'd3) begin
          // Result is registered on entry to DONE so it is visible with done.
          if (win_q || win_hit) begin
            win_con_d = player_q ? 2'b10 : 2'b01;
          end else if (&empty_q) begin
            draw_d = 1'b1;
          end
          state_d = S_DONE;
        end else begin
          dir_d = dir_q + 2'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      col_mask_q <= 7'd0;
      player_q   <= 1'b0;
      col_q      <= 3'd0;
      row_q      <= 3'd0;
      dir_q      <= 2'd0;
      win_q      <= 1'b0;
      err_q      <= 1'b0;
      empty_q    <= 42'd0;
      data_q     <= 42'd0;
      win_con_q  <= 2'b00;
      draw_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      col_mask_q <= col_mask_d;
      player_q   <= player_d;
      col_q      <= col_d;
      row_q      <= row_d;
      dir_q      <= dir_d;
      win_q      <= win_d;
      err_q      <= err_d;
      empty_q    <= empty_d;
      data_q     <= data_d;
      win_con_q  <= win_con_d;
      draw_q     <= draw_d;
    end
  end

  assign game_data = data_q;
  assign empty     = empty_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign error     = (state_q == S_DONE) && err_q;
  assign win_con   = win_con_q;
  assign draw      = draw_q;
  assign game_over = (win_con_q != 2'b00) || draw_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_c4_drop_engine.sv
// Self-checking bench for c4_drop_engine. A board model predicts landing row,
// latency and error for each drop; the prediction is queued when the drop is
// driven and popped when done appears. Wins are found by scanning every
// 4-cell window of the model board.
module tb_c4_drop_engine;

  logic        clk;
  logic        reset;
  logic        drop_req;
  logic [6:0]  column;
  logic        player;
  logic [41:0] game_data;
  logic [41:0] empty;
  logic        busy;
  logic        done;
  logic        error;
  logic [1:0]  win_con;
  logic        draw;
  logic        game_over;
  logic [2:0]  dbg_state;

  c4_drop_engine dut (
    .clk       (clk),
    .reset     (reset),
    .drop_req  (drop_req),
    .column    (column),
    .player    (player),
    .game_data (game_data),
    .empty     (empty),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .win_con   (win_con),
    .draw      (draw),
    .game_over (game_over),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  // Scoreboard entry: {error, latency[4:0]}
  logic [5:0]  exp_q[$];

  logic [41:0] m_occ;
  logic [41:0] m_own;
  logic [1:0]  m_win;
  logic        m_draw;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic apply_reset();
    @(negedge clk);
    reset    = 1'b1;
    drop_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset  = 1'b0;
    m_occ  = '0;
    m_own  = '0;
    m_win  = 2'b00;
    m_draw = 1'b0;
    exp_q.delete();
  endtask

  // ---------------- model ----------------
  function automatic logic model_has_win(input logic [41:0] occ,
                                         input logic [41:0] own,
                                         input logic pl);
    logic found;
    logic ok;
    int   dr, dc, rr, cc;
    found = 1'b0;
    for (int r = 0; r < 6; r++) begin
      for (int c = 0; c < 7; c++) begin
        for (int d = 0; d < 4; d++) begin
          dr = (d == 0) ? 0 : 1;
          dc = (d == 0) ? 1 : (d == 1) ? 0 : (d == 2) ? 1 : -1;
          ok = 1'b1;
          for (int k = 0; k < 4; k++) begin
            rr = r + k * dr;
            cc = c + k * dc;
            if (rr < 0 || rr > 5 || cc < 0 || cc > 6) ok = 1'b0;
            else if (!(occ[rr*7+cc] && own[rr*7+cc] == pl)) ok = 1'b0;
          end
          if (ok) found = 1'b1;
        end
      end
    end
    return found;
  endfunction

  task automatic model_drop(input logic [6:0] col, input logic pl,
                            output logic e_err, output int e_lat);
    int c, r;
    c = 0;
    r = -1;
    if ($countones(col) != 1) begin
      e_err = 1'b1;
      e_lat = 2;
    end else begin
      for (int i = 0; i < 7; i++) if (col[i]) c = 6 - i;
      for (int rr = 0; rr < 6; rr++) if (r < 0 && !m_occ[rr*7+c]) r = rr;
      if (r < 0) begin
        e_err = 1'b1;
        e_lat = 8;
      end else begin
        e_err = 1'b0;
        e_lat = 8 + r;
        m_occ[r*7+c] = 1'b1;
        m_own[r*7+c] = pl;
        if (model_has_win(m_occ, m_own, pl)) m_win = pl ? 2'b10 : 2'b01;
        else if (&m_occ) m_draw = 1'b1;
      end
    end
  endtask

  function automatic logic [6:0] col_mask(input int c);
    logic [6:0] m;
    m = 7'b1000000 >> c;
    return m;
  endfunction

  // ---------------- driver / scoreboard ----------------
  // intrude=1 pulses drop_req again while the engine is busy.
  task automatic do_drop(input logic [6:0] col, input logic pl, input logic intrude);
    logic       e_err;
    int         e_lat;
    logic [5:0] e;
    int         lat;
    model_drop(col, pl, e_err, e_lat);
    exp_q.push_back({e_err, 5'(e_lat)});
    @(negedge clk);
    drop_req = 1'b1;
    column   = col;
    player   = pl;
    @(negedge clk);
    drop_req = 1'b0;
    column   = 7'($urandom_range(0, 127));
    player   = 1'($urandom_range(0, 1));
    lat = 1;
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL busy_after_accept: busy=%b required 1", busy);
    end
    while (done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
      drop_req = (intrude && lat == 3);
    end
    drop_req = 1'b0;
    e = exp_q.pop_front();
    tests_run++;
    if (done !== 1'b1) begin
      tests_failed++;
      $display("FAIL done_timeout: no done within %0d cycles, required latency %0d", lat, e[4:0]);
    end else if (lat != int'(e[4:0])) begin
      tests_failed++;
      $display("FAIL latency: got %0d required %0d (col=%b)", lat, e[4:0], col);
    end
    tests_run++;
    if (error !== e[5]) begin
      tests_failed++;
      $display("FAIL error_flag: got %b required %b (col=%b)", error, e[5], col);
    end
    @(negedge clk);
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL idle_after_done: busy=%b done=%b required 0 0", busy, done);
    end
  endtask

  // No done and no busy for n cycles (ignored requests / aborted requests).
  task automatic watch_quiet(input int n, input string name);
    logic saw;
    saw = 1'b0;
    repeat (n) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) saw = 1'b1;
    end
    tests_run++;
    if (saw) begin
      tests_failed++;
      $display("FAIL %s: saw busy/done activity, required none", name);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset    = 1'b1;
    drop_req = 1'b1;
    column   = 7'b1000000;
    player   = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({game_data, empty, busy, done, error, win_con, draw, game_over} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got data=%h empty=%h busy=%b done=%b err=%b win=%b draw=%b go=%b required all 0",
               game_data, empty, busy, done, error, win_con, draw, game_over);
    end
    drop_req = 1'b0;
    apply_reset();
  endtask

  task automatic test_single_drop();
    apply_reset();
    do_drop(7'b1000000, 1'b0, 1'b0);
    tests_run++;
    if (empty !== 42'h1 || game_data !== 42'h0 || win_con !== 2'b00) begin
      tests_failed++;
      $display("FAIL single_drop_board: empty=%h data=%h win=%b required 1 0 00", empty, game_data, win_con);
    end
  endtask

  task automatic test_column_full();
    logic [41:0] col3;
    apply_reset();
    col3 = '0;
    for (int i = 0; i < 6; i++) begin
      do_drop(7'b0001000, 1'(i % 2), 1'b0);
      col3[i*7+3] = 1'b1;
    end
    do_drop(7'b0001000, 1'b0, 1'b0);
    tests_run++;
    if (empty !== col3 || game_data !== m_own) begin
      tests_failed++;
      $display("FAIL column_full_board: empty=%h data=%h required %h %h", empty, game_data, col3, m_own);
    end
  endtask

  task automatic test_invalid_column();
    apply_reset();
    do_drop(col_mask(5), 1'b1, 1'b0);
    do_drop(7'b0000000, 1'b0, 1'b0);
    do_drop(7'b0000011, 1'b1, 1'b0);
    do_drop(7'b1111111, 1'b0, 1'b0);
    tests_run++;
    if (empty !== m_occ || game_data !== m_own || win_con !== 2'b00) begin
      tests_failed++;
      $display("FAIL invalid_board: empty=%h data=%h required %h %h", empty, game_data, m_occ, m_own);
    end
  endtask

  task automatic test_horizontal_win();
    apply_reset();
    for (int c = 0; c < 3; c++) begin
      do_drop(col_mask(c), 1'b0, 1'b0);
      do_drop(col_mask(c), 1'b1, 1'b0);
    end
    do_drop(col_mask(3), 1'b0, 1'b0);
    tests_run++;
    if (win_con !== 2'b01 || game_over !== 1'b1 || m_win !== 2'b01) begin
      tests_failed++;
      $display("FAIL horizontal_win: win=%b go=%b required 01 1", win_con, game_over);
    end
    // Game over: a request is ignored entirely.
    @(negedge clk);
    drop_req = 1'b1;
    column   = col_mask(6);
    player   = 1'b1;
    @(negedge clk);
    drop_req = 1'b0;
    watch_quiet(14, "ignored_after_win");
    tests_run++;
    if (empty !== m_occ || game_data !== m_own || win_con !== 2'b01) begin
      tests_failed++;
      $display("FAIL board_after_win: empty=%h data=%h win=%b required %h %h 01",
               empty, game_data, win_con, m_occ, m_own);
    end
  endtask

  task automatic test_diagonal_win();
    apply_reset();
    do_drop(col_mask(0), 1'b1, 1'b0);  // (0,0) B
    do_drop(col_mask(1), 1'b0, 1'b0);  // (0,1) R
    do_drop(col_mask(1), 1'b1, 1'b0);  // (1,1) B
    do_drop(col_mask(2), 1'b0, 1'b0);  // (0,2) R
    do_drop(col_mask(2), 1'b0, 1'b0);  // (1,2) R
    do_drop(col_mask(2), 1'b1, 1'b0);  // (2,2) B
    do_drop(col_mask(3), 1'b1, 1'b0);  // (0,3) B
    do_drop(col_mask(3), 1'b0, 1'b0);  // (1,3) R
    do_drop(col_mask(3), 1'b0, 1'b0);  // (2,3) R
    tests_run++;
    if (win_con !== 2'b00) begin
      tests_failed++;
      $display("FAIL diag_premature: win=%b required 00", win_con);
    end
    do_drop(col_mask(3), 1'b1, 1'b0);  // (3,3) B completes the diagonal
    tests_run++;
    if (win_con !== 2'b10 || game_over !== 1'b1) begin
      tests_failed++;
      $display("FAIL diagonal_win: win=%b go=%b required 10 1", win_con, game_over);
    end
  endtask

  task automatic test_no_wrap();
    apply_reset();
    do_drop(col_mask(0), 1'b0, 1'b0);  // (0,0) R
    for (int c = 4; c < 7; c++) do_drop(col_mask(c), 1'b1, 1'b0);
    do_drop(col_mask(0), 1'b1, 1'b0);  // (1,0) B, linear index 7 follows index 6
    tests_run++;
    if (win_con !== 2'b00 || game_over !== 1'b0 || empty !== m_occ) begin
      tests_failed++;
      $display("FAIL no_wrap: win=%b go=%b empty=%h required 00 0 %h", win_con, game_over, empty, m_occ);
    end
  endtask

  task automatic test_busy_ignore();
    apply_reset();
    do_drop(col_mask(2), 1'b1, 1'b1);
    watch_quiet(12, "ignored_while_busy");
    tests_run++;
    if (empty !== m_occ || game_data !== m_own) begin
      tests_failed++;
      $display("FAIL busy_ignore_board: empty=%h data=%h required %h %h", empty, game_data, m_occ, m_own);
    end
  endtask

  task automatic test_draw();
    apply_reset();
    for (int r = 0; r < 6; r++) begin
      for (int c = 0; c < 7; c++) begin
        do_drop(col_mask(c), 1'((c + r / 2) % 2), 1'b0);
      end
    end
    tests_run++;
    if (draw !== 1'b1 || win_con !== 2'b00 || game_over !== 1'b1) begin
      tests_failed++;
      $display("FAIL draw_flags: draw=%b win=%b go=%b required 1 00 1", draw, win_con, game_over);
    end
    tests_run++;
    if (empty !== {42{1'b1}} || game_data !== m_own || m_draw !== 1'b1) begin
      tests_failed++;
      $display("FAIL draw_board: empty=%h data=%h required all-ones %h", empty, game_data, m_own);
    end
  endtask

  task automatic test_reset_mid_scan();
    logic early_done;
    apply_reset();
    for (int i = 0; i < 3; i++) do_drop(col_mask(0), 1'(i % 2), 1'b0);
    @(negedge clk);
    drop_req = 1'b1;
    column   = col_mask(0);
    player   = 1'b0;
    @(negedge clk);  // cycle T+1
    drop_req   = 1'b0;
    early_done = done;
    @(negedge clk);  // T+2
    early_done = early_done | done;
    @(negedge clk);  // T+3, SCAN of row 1
    early_done = early_done | done;
    reset = 1'b1;
    @(negedge clk);
    tests_run++;
    if (early_done || {game_data, empty, busy, done, error, win_con, draw, game_over} !== '0) begin
      tests_failed++;
      $display("FAIL reset_mid_scan: early_done=%b data=%h empty=%h busy=%b done=%b required all 0",
               early_done, game_data, empty, busy, done);
    end
    reset  = 1'b0;
    m_occ  = '0;
    m_own  = '0;
    m_win  = 2'b00;
    m_draw = 1'b0;
    watch_quiet(14, "no_done_after_abort");
    do_drop(col_mask(0), 1'b1, 1'b0);  // board really cleared: lands on row 0
  endtask

  initial begin
    reset    = 1'b1;
    drop_req = 1'b0;
    column   = 7'd0;
    player   = 1'b0;
    test_reset();
    test_single_drop();
    test_column_full();
    test_invalid_column();
    test_horizontal_win();
    test_diagonal_win();
    test_no_wrap();
    test_busy_ignore();
    test_draw();
    test_reset_mid_scan();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/c4_drop_engine.md
Name: c4_drop_engine

Overview:
- Writer side of the 42-cell board interface (game_data/empty) that the VGA renderer reads.
- Accepts a column-drop request from the turn logic (one-hot column from the switches, plus the player bit).
- Finds the lowest free cell, writes the piece, then checks for a 4-in-a-row through that cell and for a full board.
- Reports completion, full-column/invalid errors and the win condition to the 7-seg and turn logic.

Parameters:
- COLS, 7, board columns (fixed geometry; index math below assumes 7)
- ROWS, 6, board rows (fixed geometry; index math below assumes 6)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high; clears board and all state
- drop_req  in  1  single-cycle request pulse
- column  in  7  one-hot column select; bit 6 = column 1 (c=0), bit 0 = column 7 (c=6)
- player  in  1  0 = player 1 (red), 1 = player 2 (blue); sampled with drop_req
- game_data  out  42  owner bit per cell, bit index = r*7 + c, r=0 bottom row; 0 when empty
- empty  out  42  1 = cell taken, same indexing
- busy  out  1  high from accept until the done cycle inclusive
- done  out  1  one-cycle pulse ending each accepted request
- error  out  1  valid with done; 1 = column full or column not one-hot
- win_con  out  2  00 none/draw, 01 player 1, 10 player 2; sticky
- draw  out  1  sticky; board full with no winner
- game_over  out  1  sticky; win_con != 00 or draw

Behaviour:
- Reset: every output is 0; state IDLE. Reset overrides all other events.
- Reset mid-operation aborts the request: no done, board cleared.
- IDLE: on drop_req=1 with busy=0 and game_over=0, latch column and player, then go to CHECK.
  - drop_req while busy or while game_over is ignored: no done, no state change.
- CHECK (1 cycle):
  - Column not exactly one-hot (zero bits or more than one bit): go to DONE with error=1.
  - Otherwise decode c, set r=0, go to SCAN.
- SCAN (1 cycle per row):
  - empty[r*7+c]=0: record r, go to WRITE.
  - Else if r=5: go to DONE with error=1 (column full).
  - Else r=r+1.
- WRITE (1 cycle): set empty[r*7+c]=1 and game_data[r*7+c]=player. Board outputs update at the end of this cycle.
- WIN (4 cycles): one direction per cycle, in order: horizontal, vertical, diagonal up-right, diagonal up-left.
  - For each direction, count contiguous same-player taken cells on both sides of (r,c), up to 3 per side, with bounds checks and no wrap across row edges.
  - A count of at least 3 plus the placed cell sets a win flag.
- DONE (1 cycle): done=1, error as determined, then return to IDLE.
  - If win flag is set: win_con = player ? 10 : 01.
  - Else if all 42 empty bits are 1: draw=1.
  - game_over follows win_con and draw.
  - Error requests leave the board, win_con and draw unchanged.
- Latency from drop_req high at cycle T (for N occupied rows below the landing cell, N = 0..5):
  - Successful drop: done at T+8+N.
  - Full column: done at T+8 (CHECK at T+1, SCAN T+2..T+7).
  - Invalid column: done at T+2.
- busy is high from T+1 through the done cycle.
- game_data and empty change only in WRITE or on reset. They are always glitch-free registered outputs for the VGA clock domain (same clk).

Test Plan:
- Reset, then drop_req with column=7'b1000000, player=0 -> done at T+8, error=0; empty[0]=1, game_data[0]=0; all other bits 0; win_con=00.
- Six drops into column 4 (7'b0001000) alternating players, then a seventh -> seventh done at T+8 with error=1; empty bits 3,10,17,24,31,38 all set; board unchanged by the seventh drop.
- column=7'b0000000 and column=7'b0000011 -> done at T+2, error=1, board unchanged.
- Player 1 bottom row in c=0..3, with player 2 stacked on c=0..2 -> after the fourth player 1 drop: win_con=01, game_over=1; a further drop_req produces no done and busy stays 0.
- Diagonal win for player 2, ending at (r=3,c=3) placed last, up-right from (0,0) -> win_con=10. Also place pieces at (r=0,c=4..6) plus (r=1,c=0) and confirm no wrap-around win is reported.
- Fill all 42 cells in a no-win pattern -> last done has draw=1, win_con=00, game_over=1. Assert reset mid-SCAN on a separate run -> no done, all outputs 0 on the next cycle.
